// File: rtl/mesh_traffic_node.sv
// Per-tile NoC traffic generator and checker: injects configurable bursts of
// 64-bit flits into the local NIC port and checks/timestamps flits ejected at
// this tile (signature, per-source sequence, latency).
module mesh_traffic_node #(
    parameter int          MESH_X    = 4,
    parameter int          MESH_Y    = 4,
    parameter int          MY_X      = 0,
    parameter int          MY_Y      = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  cfg_dst_x,
    input  logic [3:0]  cfg_dst_y,
    input  logic [15:0] cfg_count,
    input  logic [7:0]  cfg_gap,
    input  logic [1:0]  cfg_vc_mode,
    input  logic        cfg_bp_en,
    input  logic        clr_stats,
    output logic        nic_si,
    output logic [63:0] nic_di,
    input  logic        nic_ri,
    input  logic        nic_so,
    input  logic [63:0] nic_do,
    output logic        nic_ro,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        cfg_err,
    output logic [15:0] tx_sent,
    output logic [15:0] rx_count,
    output logic [15:0] rx_sig_err,
    output logic [15:0] rx_seq_err,
    output logic [15:0] lat_max,
    output logic [31:0] lat_sum
);
    localparam int         NODES  = MESH_X * MESH_Y;
    localparam int         IDX_W  = (NODES > 1) ? $clog2(NODES) : 1;
    localparam logic [3:0] SELF_X = 4'(MY_X);
    localparam logic [3:0] SELF_Y = 4'(MY_Y);
    localparam logic [7:0] SIG    = 8'hA5;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  dst_x, dst_y;
    logic [15:0] count;
    logic [7:0]  gap, gap_left;
    logic [1:0]  vc_mode;
    logic [15:0] seq, ts_now, ts_hold, lfsr;
    logic        presented;
    logic        cfg_bad, launch, transfer, last_flit;
    logic [3:0]  hop_x, hop_y;
    logic        dir_x, dir_y, vc_bit;
    logic [15:0] ts_field;
    logic [63:0] flit;

    assign cfg_bad   = (int'(cfg_dst_x) >= MESH_X) || (int'(cfg_dst_y) >= MESH_Y);
    assign launch    = (state == S_IDLE) && start && !cfg_bad;
    assign transfer  = (state == S_SEND) && nic_ri;
    assign last_flit = (tx_sent + 16'd1) == count;
    assign nic_si    = (state == S_SEND);
    assign tx_busy   = (state == S_SEND) || (state == S_GAP);
    assign tx_done   = (state == S_DONE);

    // TX state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // TX next-state decode.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nx
        // unassigned and infers a latch.
        state_nx = state;
        case (state)
            S_IDLE: if (launch) state_nx = (cfg_count == 16'd0) ? S_DONE : S_SEND;
            S_SEND: if (transfer) begin
                        if (last_flit)          state_nx = S_DONE;
                        else if (gap != 8'd0)   state_nx = S_GAP;
                    end
            S_GAP:  if (gap_left == 8'd1) state_nx = S_SEND;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Burst configuration, sequence/sent counters, gap timer and ts hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst_x     <= '0;
            dst_y     <= '0;
            count     <= '0;
            gap       <= '0;
            vc_mode   <= '0;
            seq       <= '0;
            tx_sent   <= '0;
            gap_left  <= '0;
            ts_hold   <= '0;
            presented <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= (state == S_IDLE) && start && cfg_bad;
            if (launch && cfg_count != 16'd0) begin
                dst_x     <= cfg_dst_x;
                dst_y     <= cfg_dst_y;
                count     <= cfg_count;
                gap       <= cfg_gap;
                vc_mode   <= cfg_vc_mode;
                seq       <= '0;
                tx_sent   <= '0;
                presented <= 1'b0;
            end
            if (state == S_SEND) begin
                // The timestamp is frozen on first presentation of a flit.
                if (!presented) ts_hold <= ts_now;
                presented <= !nic_ri;
            end
            if (transfer) begin
                tx_sent  <= tx_sent + 16'd1;
                seq      <= seq + 16'd1;
                gap_left <= gap;
            end else if (state == S_GAP) begin
                gap_left <= gap_left - 8'd1;
            end
        end
    end

    // Outgoing flit assembly from the latched burst configuration.
    always_comb begin
        dir_x = dst_x < SELF_X;
        dir_y = dst_y < SELF_Y;
        hop_x = dir_x ? (SELF_X - dst_x) : (dst_x - SELF_X);
        hop_y = dir_y ? (SELF_Y - dst_y) : (dst_y - SELF_Y);
        case (vc_mode)
            2'd0:    vc_bit = 1'b0;
            2'd1:    vc_bit = 1'b1;
            default: vc_bit = seq[0];
        endcase
        ts_field = presented ? ts_hold : ts_now;
        flit = {vc_bit, dir_x, dir_y, 5'b0, hop_x, hop_y, SELF_X, SELF_Y,
                seq, ts_field, SIG};
    end

    assign nic_di = nic_si ? flit : '0;

    // Free-running timestamp and back-pressure LFSR (x^16+x^14+x^13+x^11+1).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_now <= '0;
            lfsr   <= LFSR_SEED;
        end else begin
            ts_now <= ts_now + 16'd1;
            lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign nic_ro = cfg_bp_en ? lfsr[0] : 1'b1;

    // RX decode of the ejected flit.
    logic             accept, sig_ok, src_ok;
    logic [IDX_W-1:0] src_idx;
    logic [15:0]      rx_seq, lat;
    logic [32:0]      sum_ext;
    logic [15:0]      exp_seq [NODES];
    logic             unused_bits;

    assign accept      = nic_so && nic_ro;
    assign sig_ok      = nic_do[7:0] == SIG;
    assign src_ok      = (int'(nic_do[47:44]) < MESH_X) && (int'(nic_do[43:40]) < MESH_Y);
    assign src_idx     = IDX_W'(int'(nic_do[43:40]) * MESH_X + int'(nic_do[47:44]));
    assign rx_seq      = nic_do[39:24];
    assign lat         = ts_now - nic_do[23:8];
    assign sum_ext     = {1'b0, lat_sum} + 33'(lat);
    assign unused_bits = ^nic_do[63:48];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    // RX statistics and per-source expected-sequence table.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count   <= '0;
            rx_sig_err <= '0;
            rx_seq_err <= '0;
            lat_max    <= '0;
            lat_sum    <= '0;
            // NOTE: the expected table is flop-based and must be cleared by
            // reset, so it cannot map onto a RAM macro.
            for (int i = 0; i < NODES; i++) exp_seq[i] <= '0;
        end else if (clr_stats) begin
            rx_count   <= '0;
            rx_sig_err <= '0;
            rx_seq_err <= '0;
            lat_max    <= '0;
            lat_sum    <= '0;
            for (int i = 0; i < NODES; i++) exp_seq[i] <= '0;
        end else if (accept) begin
            if (!sig_ok) begin
                rx_sig_err <= sat_inc(rx_sig_err);
            end else begin
                rx_count <= sat_inc(rx_count);
                if (!src_ok) begin
                    rx_seq_err <= sat_inc(rx_seq_err);
                end else begin
                    if (rx_seq != exp_seq[src_idx]) rx_seq_err <= sat_inc(rx_seq_err);
                    exp_seq[src_idx] <= rx_seq + 16'd1;
                end
                lat_sum <= sum_ext[32] ? '1 : sum_ext[31:0];
                if (lat > lat_max) lat_max <= lat;
            end
        end
    end
endmodule

// File: tb/tb_mesh_traffic_node.sv
// Self-checking bench for mesh_traffic_node: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level behavioural model.
module tb_mesh_traffic_node;
    localparam int          MX   = 4;
    localparam int          MYY  = 4;
    localparam int          TX   = 3;
    localparam int          TY   = 0;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, cfg_bp_en, clr_stats;
    logic [3:0]  cfg_dst_x, cfg_dst_y;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_gap;
    logic [1:0]  cfg_vc_mode;
    logic        nic_si, nic_ri, nic_so, nic_ro;
    logic [63:0] nic_di, nic_do;
    logic        tx_busy, tx_done, cfg_err;
    logic [15:0] tx_sent, rx_count, rx_sig_err, rx_seq_err, lat_max;
    logic [31:0] lat_sum;

    logic        loop, drv_ri, drv_so;
    logic [63:0] drv_do;
    assign nic_ri = loop ? nic_ro : drv_ri;
    assign nic_so = loop ? nic_si : drv_so;
    assign nic_do = loop ? nic_di : drv_do;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mesh_traffic_node #(.MESH_X(MX), .MESH_Y(MYY), .MY_X(TX), .MY_Y(TY), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_dst_x(cfg_dst_x), .cfg_dst_y(cfg_dst_y),
        .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_vc_mode(cfg_vc_mode), .cfg_bp_en(cfg_bp_en),
        .clr_stats(clr_stats), .nic_si(nic_si), .nic_di(nic_di), .nic_ri(nic_ri), .nic_so(nic_so),
        .nic_do(nic_do), .nic_ro(nic_ro), .tx_busy(tx_busy), .tx_done(tx_done), .cfg_err(cfg_err),
        .tx_sent(tx_sent), .rx_count(rx_count), .rx_sig_err(rx_sig_err), .rx_seq_err(rx_seq_err),
        .lat_max(lat_max), .lat_sum(lat_sum)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flit a tile at (TX,TY) must send toward (dx,dy), computed from the field rules.
    function automatic logic [63:0] mk_flit(input logic [3:0] dx, input logic [3:0] dy,
                                            input logic [1:0] mode, input logic [15:0] sq,
                                            input logic [15:0] ts);
        int hx, hy;
        logic [63:0] f;
        hx = int'(dx) - TX;
        hy = int'(dy) - TY;
        f = '0;
        f[63]    = (mode == 2'd0) ? 1'b0 : (mode == 2'd1) ? 1'b1 : sq[0];
        f[62]    = hx < 0;
        f[61]    = hy < 0;
        f[55:52] = 4'(hx < 0 ? -hx : hx);
        f[51:48] = 4'(hy < 0 ? -hy : hy);
        f[47:44] = 4'(TX);
        f[43:40] = 4'(TY);
        f[39:24] = sq;
        f[23:8]  = ts;
        f[7:0]   = 8'hA5;
        return f;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    logic        m_active, m_pres, m_done, m_err;
    int          m_wait, m_k, m_cnt, m_gap;
    logic [3:0]  m_dx, m_dy;
    logic [1:0]  m_mode;
    logic [15:0] m_sent, m_ts, m_tsf, m_lfsr;
    longint      r_cnt, r_sig, r_seq, r_max, r_sum;
    int          m_exp [int];

    initial begin
        forever begin
            logic exp_si, idle_now, nd, ne;
            logic [63:0] f;
            int idx, e, lt;
            @(negedge clk);
            if (!reset) begin
                m_active = 0; m_pres = 0; m_done = 0; m_err = 0;
                m_wait = 0; m_k = 0; m_sent = 0; m_ts = 0; m_lfsr = SEED;
                r_cnt = 0; r_sig = 0; r_seq = 0; r_max = 0; r_sum = 0;
                m_exp.delete();
            end
            exp_si = m_active && (m_wait == 0);
            check("si", nic_si, exp_si);
            if (exp_si) begin
                if (!m_pres) begin m_tsf = m_ts; m_pres = 1; end
                check("di", nic_di, mk_flit(m_dx, m_dy, m_mode, 16'(m_k), m_tsf));
            end
            check("busy", tx_busy, m_active);
            check("done", tx_done, m_done);
            check("cfg_err", cfg_err, m_err);
            check("tx_sent", tx_sent, m_sent);
            check("ro", nic_ro, cfg_bp_en ? m_lfsr[0] : 1'b1);
            check("rx_count", rx_count, r_cnt);
            check("rx_sig_err", rx_sig_err, r_sig);
            check("rx_seq_err", rx_seq_err, r_seq);
            check("lat_max", lat_max, r_max);
            check("lat_sum", lat_sum, r_sum);
            if (reset) begin
                idle_now = !(m_active || m_done);
                nd = 0; ne = 0;
                if (exp_si && nic_ri) begin
                    m_k++; m_sent++; m_pres = 0;
                    if (m_k == m_cnt) begin m_active = 0; nd = 1; end
                    else m_wait = m_gap;
                end else if (m_active && m_wait > 0) begin
                    m_wait--;
                end
                if (idle_now && start) begin
                    if (int'(cfg_dst_x) >= MX || int'(cfg_dst_y) >= MYY) ne = 1;
                    else if (cfg_count == 0) nd = 1;
                    else begin
                        m_active = 1; m_k = 0; m_sent = 0; m_wait = 0; m_pres = 0;
                        m_cnt = int'(cfg_count); m_gap = int'(cfg_gap);
                        m_dx = cfg_dst_x; m_dy = cfg_dst_y; m_mode = cfg_vc_mode;
                    end
                end
                m_done = nd; m_err = ne;
                if (clr_stats) begin
                    r_cnt = 0; r_sig = 0; r_seq = 0; r_max = 0; r_sum = 0;
                    m_exp.delete();
                end else if (nic_so && nic_ro) begin
                    f = nic_do;
                    if (f[7:0] != 8'hA5) begin
                        r_sig = (r_sig < 65535) ? r_sig + 1 : r_sig;
                    end else begin
                        r_cnt = (r_cnt < 65535) ? r_cnt + 1 : r_cnt;
                        idx = int'(f[43:40]) * MX + int'(f[47:44]);
                        e = m_exp.exists(idx) ? m_exp[idx] : 0;
                        if (int'(f[39:24]) != e) r_seq = (r_seq < 65535) ? r_seq + 1 : r_seq;
                        m_exp[idx] = (int'(f[39:24]) + 1) % 65536;
                        lt = (int'(m_ts) - int'(f[23:8]) + 65536) % 65536;
                        r_sum = r_sum + lt;
                        if (r_sum > 64'hFFFF_FFFF) r_sum = 64'hFFFF_FFFF;
                        if (lt > r_max) r_max = lt;
                    end
                end
                m_ts++;
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] dx, input logic [3:0] dy, input logic [15:0] cnt,
                            input logic [7:0] gp, input logic [1:0] mode);
        cfg_dst_x = dx; cfg_dst_y = dy; cfg_count = cnt; cfg_gap = gp; cfg_vc_mode = mode;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic eject(input logic [63:0] f);
        drv_so = 1'b1; drv_do = f;
        tick();
        drv_so = 1'b0; drv_do = '0;
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    initial begin
        logic [6:0]  pat;
        logic [2:0]  vcs;
        logic        got, saw0, saw1;
        reset = 1'b0; start = 1'b0; cfg_bp_en = 1'b0; clr_stats = 1'b0;
        cfg_dst_x = '0; cfg_dst_y = '0; cfg_count = '0; cfg_gap = '0; cfg_vc_mode = '0;
        loop = 1'b0; drv_ri = 1'b1; drv_so = 1'b0; drv_do = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ro", nic_ro, 1'b1);
        check("rst_si", nic_si, 1'b0);
        check("rst_di", nic_di, 64'h0);
        @(posedge clk); #1 reset = 1'b1;
        tick();

        // 1: four back-to-back flits toward (3,3).
        do_start(4'd3, 4'd3, 16'd4, 8'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_si", nic_si, 1'b1);
            check("t1_hdr", nic_di[63:40], 24'h000330);
            check("t1_seq", nic_di[39:24], 16'(i));
            check("t1_sig", nic_di[7:0], 8'hA5);
        end
        @(negedge clk);
        check("t1_done", tx_done, 1'b1);
        @(negedge clk);
        check("t1_done_once", tx_done, 1'b0);
        check("t1_sent", tx_sent, 16'd4);
        tick();

        // 2: single vc=1 flit toward (0,3), stalled for 5 cycles.
        drv_ri = 1'b0;
        do_start(4'd0, 4'd3, 16'd1, 8'd0, 2'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_si_hold", nic_si, 1'b1);
            check("t2_hdr", nic_di[63:40], 24'hC03330);
        end
        @(posedge clk); #1 drv_ri = 1'b1;
        @(negedge clk);
        check("t2_si", nic_si, 1'b1);
        @(negedge clk);
        check("t2_done", tx_done, 1'b1);
        check("t2_sent", tx_sent, 16'd1);
        tick();

        // 3: gap of 2, alternating vc.
        do_start(4'd1, 4'd1, 16'd3, 8'd2, 2'd2);
        pat = '0; vcs = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pat = {pat[5:0], nic_si};
            if (nic_si) vcs = {vcs[1:0], nic_di[63]};
        end
        check("t3_pattern", pat, 7'b1001001);
        check("t3_vc", vcs, 3'b010);
        @(negedge clk);
        check("t3_done", tx_done, 1'b1);
        tick();

        // 4: 100-flit loopback under random back-pressure.
        cfg_bp_en = 1'b1;
        pulse_clr();
        loop = 1'b1;
        do_start(4'd2, 4'd1, 16'd100, 8'd0, 2'd3);
        got = 0; saw0 = 0; saw1 = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (nic_ro) saw1 = 1; else saw0 = 1;
            if (tx_done) got = 1;
        end
        check("t4_timeout", got, 1'b1);
        @(negedge clk);
        check("t4_rx_count", rx_count, 16'd100);
        check("t4_seq_err", rx_seq_err, 16'd0);
        check("t4_sig_err", rx_sig_err, 16'd0);
        check("t4_ro_toggles", {saw0, saw1}, 2'b11);
        tick();
        loop = 1'b0; cfg_bp_en = 1'b0;
        tick();

        // 5: direct ejects from (1,2): seq 0,1,3 then a bad signature.
        pulse_clr();
        eject({24'h0, 4'd1, 4'd2, 16'd0, 16'h0000, 8'hA5});
        eject({24'h0, 4'd1, 4'd2, 16'd1, 16'h0000, 8'hA5});
        eject({24'h0, 4'd1, 4'd2, 16'd3, 16'h0000, 8'hA5});
        eject({24'h0, 4'd1, 4'd2, 16'd4, 16'h0000, 8'h00});
        @(negedge clk);
        check("t5_rx_count", rx_count, 16'd3);
        check("t5_seq_err", rx_seq_err, 16'd1);
        check("t5_sig_err", rx_sig_err, 16'd1);
        tick();
        pulse_clr();
        @(negedge clk);
        check("t5_clr", {rx_count, rx_seq_err, rx_sig_err, lat_max}, 64'h0);
        check("t5_clr_sum", lat_sum, 32'h0);
        tick();

        // 6: bad destination, empty burst, reset mid-burst.
        do_start(4'd4, 4'd0, 16'd5, 8'd0, 2'd0);
        @(negedge clk);
        check("t6_cfg_err", cfg_err, 1'b1);
        check("t6_si", nic_si, 1'b0);
        @(negedge clk);
        check("t6_cfg_err_pulse", cfg_err, 1'b0);
        tick();
        do_start(4'd1, 4'd1, 16'd0, 8'd0, 2'd0);
        @(negedge clk);
        check("t6_zero_done", tx_done, 1'b1);
        check("t6_zero_si", nic_si, 1'b0);
        tick();
        do_start(4'd0, 4'd0, 16'd50, 8'd1, 2'd0);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("t6_rst_si", nic_si, 1'b0);
        check("t6_rst_busy", tx_busy, 1'b0);
        tick();
        @(posedge clk); #1 reset = 1'b1;
        tick();

        // Randomized traffic: bursts with random stalls plus random ejects.
        for (int c = 0; c < 4000; c++) begin
            drv_ri = ($urandom % 4) != 0;
            drv_so = ($urandom % 3) == 0;
            drv_do = {24'h0, 4'($urandom % 4), 4'($urandom % 4), 16'($urandom % 4),
                      16'($urandom), (($urandom % 8) == 0) ? 8'h3C : 8'hA5};
            clr_stats = ($urandom % 500) == 0;
            if (($urandom % 200) == 0) cfg_bp_en = ~cfg_bp_en;
            if (!tx_busy && ($urandom % 6) == 0) begin
                cfg_dst_x = 4'($urandom_range(0, 4));
                cfg_dst_y = 4'($urandom_range(0, 4));
                cfg_count = 16'($urandom_range(0, 6));
                cfg_gap = 8'($urandom_range(0, 3));
                cfg_vc_mode = 2'($urandom % 4);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0; drv_so = 1'b0; clr_stats = 1'b0; drv_ri = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
